// File: rtl/ece178_irq_pkg.sv
// Shared constants for the ECE178 interrupt aggregator: register addresses
// and the data/vector field geometry.
package ece178_irq_pkg;

  localparam int DATA_W        = 16;
  localparam int MAX_SRC       = 16;
  localparam int VEC_VALID_BIT = 15;
  localparam int VEC_IDX_W     = 4;

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
  localparam logic [2:0] ADDR_VECTOR   = 3'd4;
  localparam logic [2:0] ADDR_RAW      = 3'd5;
  localparam logic [2:0] ADDR_FORCE    = 3'd6;

endpackage

// File: rtl/ece178_irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of the input vector.
module ece178_irq_prio_enc
  import ece178_irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]   i_vec,
  output logic                 o_valid,
  output logic [VEC_IDX_W-1:0] o_idx
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_valid = 1'b1;
        o_idx   = i[VEC_IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ece178_irq_aggregator.sv
// Interrupt aggregator: per-source edge/level qualification, pending latch,
// mask and a lowest-index-first vector register behind a small Avalon slave.
module ece178_irq_aggregator
  import ece178_irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  output logic               irq
);

  logic [NUM_SRC-1:0]   r_pending;
  logic [NUM_SRC-1:0]   r_mask;
  logic [NUM_SRC-1:0]   r_edgeSel;
  logic [NUM_SRC-1:0]   r_srcD;

  logic                 w_wr;
  logic [NUM_SRC-1:0]   w_active;
  logic [NUM_SRC-1:0]   w_rise;
  logic [NUM_SRC-1:0]   w_clr;
  logic [NUM_SRC-1:0]   w_force;
  logic [NUM_SRC-1:0]   w_ack;
  logic [NUM_SRC-1:0]   w_pendNext;
  logic                 w_vecValid;
  logic [VEC_IDX_W-1:0] w_vecIdx;
  logic [DATA_W-1:0]    w_rdMux;
  logic                 w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_active = r_pending & r_mask;
  assign w_rise   = src & ~r_srcD;
  assign w_unused = ^writedata;

  ece178_irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prioEnc (
    .i_vec   (w_active),
    .o_valid (w_vecValid),
    .o_idx   (w_vecIdx)
  );

  // The VECTOR ack clears whichever source the vector reports right now.
  always_comb begin
    w_clr   = '0;
    w_force = '0;
    w_ack   = '0;
    if (w_wr && address == ADDR_PENDING) w_clr   = writedata[NUM_SRC-1:0];
    if (w_wr && address == ADDR_FORCE)   w_force = writedata[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      w_ack[i] = w_wr && (address == ADDR_VECTOR) && w_vecValid &&
                 (w_vecIdx == i[VEC_IDX_W-1:0]);
    end
  end

  assign w_pendNext = (r_edgeSel & ((r_pending & ~(w_clr | w_ack)) | w_rise | w_force)) |
                      (~r_edgeSel & src);

  always_comb begin
    w_rdMux = '0;
    case (address)
      ADDR_PENDING:  w_rdMux[NUM_SRC-1:0] = r_pending;
      ADDR_MASK:     w_rdMux[NUM_SRC-1:0] = r_mask;
      ADDR_EDGE_SEL: w_rdMux[NUM_SRC-1:0] = r_edgeSel;
      ADDR_ACTIVE:   w_rdMux[NUM_SRC-1:0] = w_active;
      ADDR_VECTOR: begin
        w_rdMux[VEC_VALID_BIT]   = w_vecValid;
        w_rdMux[VEC_IDX_W-1:0]   = w_vecIdx;
      end
      ADDR_RAW:      w_rdMux[NUM_SRC-1:0] = src;
      default:       w_rdMux = '0;
    endcase
  end

  // irq is driven from the registered pending/mask, one cycle behind pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_edgeSel <= '0;
      r_srcD    <= '0;
      readdata  <= '0;
      irq       <= 1'b0;
    end else begin
      r_srcD    <= src;
      r_pending <= w_pendNext;
      if (w_wr && address == ADDR_MASK)     r_mask    <= writedata[NUM_SRC-1:0];
      if (w_wr && address == ADDR_EDGE_SEL) r_edgeSel <= writedata[NUM_SRC-1:0];
      readdata  <= w_rdMux;
      irq       <= |w_active;
    end
  end

endmodule

// File: tb/tb_ece178_irq_aggregator.sv
// Self-checking bench for the interrupt aggregator: directed test-plan steps
// followed by randomized traffic, all checked against a behavioural model.
module tb_ece178_irq_aggregator;

  localparam int N = 8;

  logic        clk;
  logic        reset;
  logic [N-1:0] src;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // Behavioural model state, one bit per source.
  logic [N-1:0] mPend, mMask, mEdge, mSrcD;

  ece178_irq_aggregator #(.NUM_SRC(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lowestActive();
    for (int i = 0; i < N; i++)
      if (mPend[i] && mMask[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] modelRead(input logic [2:0] a, input logic [N-1:0] s);
    int low;
    logic [15:0] v;
    v = 16'h0000;
    low = lowestActive();
    case (a)
      3'd0: v[N-1:0] = mPend;
      3'd1: v[N-1:0] = mMask;
      3'd2: v[N-1:0] = mEdge;
      3'd3: v[N-1:0] = mPend & mMask;
      3'd4: if (low >= 0) v = 16'h8000 + 16'(low);
      3'd5: v[N-1:0] = s;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] s, input logic cs,
                               input logic wn, input logic [2:0] a, input logic [15:0] wd);
    logic [15:0] expRd;
    logic        expIrq;
    logic [N-1:0] nPend, nMask, nEdge;
    logic        wr;
    int          low;
    logic        clrBit, setBit;
    reset = rst; src = s; chipselect = cs; write_n = wn; address = a; writedata = wd;
    wr     = cs && !wn;
    low    = lowestActive();
    expRd  = modelRead(a, s);
    expIrq = (mPend & mMask) != 0;
    nMask  = (wr && a == 3'd1) ? wd[N-1:0] : mMask;
    nEdge  = (wr && a == 3'd2) ? wd[N-1:0] : mEdge;
    for (int i = 0; i < N; i++) begin
      if (mEdge[i]) begin
        clrBit = (wr && a == 3'd0 && wd[i]) || (wr && a == 3'd4 && low == i);
        setBit = (s[i] && !mSrcD[i]) || (wr && a == 3'd6 && wd[i]);
        nPend[i] = setBit || (mPend[i] && !clrBit);
      end else begin
        nPend[i] = s[i];
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mPend = '0; mMask = '0; mEdge = '0; mSrcD = '0;
      expRd = 16'h0000; expIrq = 1'b0;
    end else begin
      mPend = nPend; mMask = nMask; mEdge = nEdge; mSrcD = s;
    end
    checkOutput("readdata", readdata, expRd);
    checkOutput("irq", {15'h0, irq}, {15'h0, expIrq});
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [15:0] wd);
    applyStimulus(1'b0, src, 1'b1, 1'b0, a, wd);
  endtask

  task automatic readReg(input logic [2:0] a);
    applyStimulus(1'b0, src, 1'b0, 1'b1, a, 16'h0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, '0, 1'b0, 1'b1, 3'd0, 16'h0);
  endtask

  initial begin
    logic [N-1:0] s;
    logic         rst, cs, wn;
    mPend = '0; mMask = '0; mEdge = '0; mSrcD = '0;
    reset = 1'b1; src = '0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 16'h0;

    // Plan 1: reset and read every address.
    doReset();
    doReset();
    checkOutput("reset_irq", {15'h0, irq}, 16'h0000);
    for (int a = 0; a < 8; a++) begin
      readReg(3'(a));
      checkOutput("reset_read", readdata, 16'h0000);
    end

    // Plan 2: single edge on src[0], then W1C.
    writeReg(3'd2, 16'h0001);
    writeReg(3'd1, 16'h0001);
    applyStimulus(1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 16'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 16'h0);
    checkOutput("edge_pending", readdata, 16'h0001);
    checkOutput("edge_irq", {15'h0, irq}, 16'h0001);
    writeReg(3'd0, 16'h0001);
    readReg(3'd0);
    checkOutput("w1c_irq", {15'h0, irq}, 16'h0000);

    // Plan 3: two edges, vector dispatch and ack.
    doReset();
    writeReg(3'd2, 16'h00FF);
    writeReg(3'd1, 16'h00FF);
    applyStimulus(1'b0, 8'h24, 1'b0, 1'b1, 3'd4, 16'h0);
    readReg(3'd4);
    checkOutput("vec_first", readdata, 16'h8002);
    writeReg(3'd4, 16'h0000);
    readReg(3'd4);
    checkOutput("vec_second", readdata, 16'h8005);
    writeReg(3'd4, 16'h0000);
    readReg(3'd4);
    checkOutput("vec_empty", readdata, 16'h0000);
    checkOutput("vec_irq", {15'h0, irq}, 16'h0000);

    // Plan 4: level mode ignores W1C and follows src.
    doReset();
    writeReg(3'd1, 16'h0008);
    applyStimulus(1'b0, 8'h08, 1'b0, 1'b1, 3'd0, 16'h0);
    applyStimulus(1'b0, 8'h08, 1'b1, 1'b0, 3'd0, 16'h0008);
    readReg(3'd0);
    checkOutput("level_pending", readdata, 16'h0008);
    checkOutput("level_irq", {15'h0, irq}, 16'h0001);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 16'h0);
    readReg(3'd0);
    checkOutput("level_drop_pending", readdata, 16'h0000);
    checkOutput("level_drop_irq", {15'h0, irq}, 16'h0000);

    // Plan 5: edge coincident with W1C, then unmask.
    doReset();
    writeReg(3'd2, 16'h0002);
    applyStimulus(1'b0, 8'h02, 1'b1, 1'b0, 3'd0, 16'h0002);
    readReg(3'd0);
    checkOutput("set_wins", readdata, 16'h0002);
    checkOutput("masked_irq", {15'h0, irq}, 16'h0000);
    writeReg(3'd1, 16'h0002);
    readReg(3'd3);
    checkOutput("unmask_irq", {15'h0, irq}, 16'h0001);

    // Plan 6: FORCE, then reset mid-interrupt.
    doReset();
    writeReg(3'd2, 16'h0010);
    writeReg(3'd1, 16'h0010);
    writeReg(3'd6, 16'h0010);
    readReg(3'd0);
    checkOutput("force_pending", readdata, 16'h0010);
    checkOutput("force_irq", {15'h0, irq}, 16'h0001);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 3'd6, 16'h00FF);
    checkOutput("midreset_irq", {15'h0, irq}, 16'h0000);
    readReg(3'd1);
    checkOutput("midreset_mask", readdata, 16'h0000);

    // Randomized traffic against the model.
    s = '0;
    for (int n = 0; n < 1500; n++) begin
      s   = s ^ (8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
      rst = ($urandom_range(0, 99) < 2);
      cs  = ($urandom_range(0, 1) == 1);
      wn  = ($urandom_range(0, 2) != 0);
      applyStimulus(rst, s, cs, wn, 3'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
